// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and helpers for the multi-cycle-aware hazard controller.
package hazard_pkg;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Width needed to count 0..maxPending outstanding operations
  function automatic int unsigned pendingWidth(input int unsigned maxPending);
    return $clog2(maxPending + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_mc_scoreboard.sv
// Register scoreboard for out-of-band multi-cycle writebacks: busy bitmap,
// outstanding-operation counter and protocol checks.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned NUM_REGS   = 2**REG_AW,
  localparam int unsigned PEND_W     = pendingWidth(MAX_PENDING)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issueValid,
  input  logic [REG_AW-1:0]   issueRd,
  input  logic                doneValid,
  input  logic [REG_AW-1:0]   doneRd,
  output logic [NUM_REGS-1:0] busy,
  output logic [PEND_W-1:0]   pending
);

  localparam logic [PEND_W-1:0] PendMax = PEND_W'(MAX_PENDING);

  logic [NUM_REGS-1:0] busyNext;
  logic [PEND_W-1:0]   pendingNext;

  // Clear on completion, then set on issue so a newer writer to the same register stays busy
  always_comb begin
    busyNext = busy;
    if (doneValid) busyNext[doneRd] = 1'b0;
    if (issueValid && (issueRd != '0)) busyNext[issueRd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Outstanding count: simultaneous issue and done cancel; never wraps either way
  always_comb begin
    pendingNext = pending;
    if (issueValid && !doneValid && (pending != PendMax)) begin
      pendingNext = pending + PEND_W'(1);
    end else if (doneValid && !issueValid && (pending != '0)) begin
      pendingNext = pending - PEND_W'(1);
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busyNext;
      pending <= pendingNext;
    end
  end

  // A completion needs an outstanding op; an issue needs a free slot
  doneWithoutPending: assert property (@(posedge clk) disable iff (reset)
    doneValid |-> (pending != '0))
    else $error("hazard_scoreboard: mc_done with no pending operation");

  issueOverLimit: assert property (@(posedge clk) disable iff (reset)
    issueValid |-> (pending != PendMax))
    else $error("hazard_scoreboard: mc_issue_e with pending at limit");

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: forwarding, load-use and scoreboard
// stalls, outstanding-op limit and redirect flushes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles/flush_cycles counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned NUM_REGS   = 2**REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_AW-1:0]   rs1_d,
  input  logic [REG_AW-1:0]   rs2_d,
  input  logic [REG_AW-1:0]   rd_d,
  input  logic                mc_op_d,
  input  logic [REG_AW-1:0]   rs1_e,
  input  logic [REG_AW-1:0]   rs2_e,
  input  logic [REG_AW-1:0]   rd_e,
  input  logic                load_e,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic [REG_AW-1:0]   rd_m,
  input  logic [REG_AW-1:0]   rd_w,
  input  logic                mc_issue_e,
  input  logic                mc_done,
  input  logic [REG_AW-1:0]   mc_rd,
  input  logic                redirect_e,
  output logic [1:0]          fwd_a_e,
  output logic [1:0]          fwd_b_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic [NUM_REGS-1:0] sb_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_cycles
`endif
);

  localparam int unsigned PEND_W = pendingWidth(MAX_PENDING);
  localparam logic [PEND_W-1:0] PendMax = PEND_W'(MAX_PENDING);

  // Reject configurations outside the supported range at elaboration
  if ((MAX_PENDING == 0) || (MAX_PENDING >= NUM_REGS) || (CNT_W == 0)) begin : gBadParams
    $error("hazard_unit_mc: MAX_PENDING or CNT_W out of range");
  end

  logic [PEND_W-1:0] pending;
  fwd_sel_e          fwdA;
  fwd_sel_e          fwdB;
  logic              loadUse;
  logic              sbHit;
  logic              capFull;
  logic              hzStall;

  hazard_scoreboard #(
    .REG_AW      (REG_AW),
    .MAX_PENDING (MAX_PENDING)
  ) uScoreboard (
    .clk        (clk),
    .reset      (reset),
    .issueValid (mc_issue_e),
    .issueRd    (rd_e),
    .doneValid  (mc_done),
    .doneRd     (mc_rd),
    .busy       (sb_busy),
    .pending    (pending)
  );

  // M result beats W result; x0 is never forwarded
  function automatic fwd_sel_e fwdSelect(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic              wrM,
    input logic [REG_AW-1:0] rdW,
    input logic              wrW
  );
    if (wrM && (rs == rdM) && (rs != '0)) return FWD_M;
    if (wrW && (rs == rdW) && (rs != '0)) return FWD_W;
    return FWD_RF;
  endfunction

  // Operand forwarding selects for E
  always_comb begin
    fwdA = fwdSelect(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    fwdB = fwdSelect(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end

  assign fwd_a_e = fwdA;
  assign fwd_b_e = fwdB;

  // Hazard sources: load-use, busy register (RAW or WAW), outstanding-op limit
  always_comb begin
    loadUse = load_e && reg_write_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    sbHit   = sb_busy[rs1_d] || sb_busy[rs2_d] || sb_busy[rd_d];
    capFull = mc_op_d && (pending == PendMax);
    hzStall = loadUse || sbHit || capFull;
  end

  // Redirect flushes D and E and overrides any stall
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (redirect_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = hzStall;
      stall_d = hzStall;
      flush_e = hzStall;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall and flush cycle counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall_d && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if ((flush_d || flush_e) && (flush_cycles != '1)) flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc (MAX_PENDING = 2). Expected control
// vectors are queued when stimulus is driven and popped at the sampling edge.
module tb_hazard_unit_mc;

  localparam int unsigned REG_AW = 5;
  localparam int          MAXP   = 2;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mc_rd;
  logic        mc_op_d, load_e, reg_write_e, reg_write_m, reg_write_w;
  logic        mc_issue_e, mc_done, redirect_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [31:0] sb_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
`endif

  hazard_unit_mc #(
    .REG_AW      (REG_AW),
    .MAX_PENDING (MAXP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .mc_op_d     (mc_op_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .load_e      (load_e),
    .reg_write_e (reg_write_e),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .mc_issue_e  (mc_issue_e),
    .mc_done     (mc_done),
    .mc_rd       (mc_rd),
    .redirect_e  (redirect_e),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .sb_busy     (sb_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  // {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e}
  logic [7:0] ctl;
  assign ctl = {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e};

  logic [7:0]  expQ[$];
  logic [31:0] mBusy = '0;
  int          mPending = 0;
  int unsigned mStall = 0, mFlush = 0;
  int          passed = 0, total = 0;

  typedef struct packed {
    logic       ld, we;
    logic [4:0] rde, rs1d, rs2d, rdd;
    logic       mcop, iss, done;
    logic [4:0] mcrd;
    logic       redir;
    logic [7:0] ex;
  } hz_t;

  typedef struct packed {
    logic [4:0] rs1e, rs2e, rdm, rdw;
    logic       wm, ww;
    logic [7:0] ex;
  } fwd_t;

  function automatic hz_t hz(input int ld, we, rde, rs1d, rs2d, rdd, mcop, iss, done, mcrd, redir, ex);
    hz_t h;
    h.ld = 1'(ld); h.we = 1'(we); h.rde = 5'(rde); h.rs1d = 5'(rs1d); h.rs2d = 5'(rs2d);
    h.rdd = 5'(rdd); h.mcop = 1'(mcop); h.iss = 1'(iss); h.done = 1'(done);
    h.mcrd = 5'(mcrd); h.redir = 1'(redir); h.ex = 8'(ex);
    return h;
  endfunction

  function automatic fwd_t fw(input int rs1e, rs2e, rdm, rdw, wm, ww, ex);
    fwd_t f;
    f.rs1e = 5'(rs1e); f.rs2e = 5'(rs2e); f.rdm = 5'(rdm); f.rdw = 5'(rdw);
    f.wm = 1'(wm); f.ww = 1'(ww); f.ex = 8'(ex);
    return f;
  endfunction

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (rs != 5'd0 && reg_write_m && rs == rd_m) return 2'b10;
    if (rs != 5'd0 && reg_write_w && rs == rd_w) return 2'b01;
    return 2'b00;
  endfunction

  // Reference control vector from current inputs and the model scoreboard
  function automatic logic [7:0] expCtl();
    logic lu, sbh, cap, h;
    lu  = load_e && reg_write_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    sbh = mBusy[rs1_d] || mBusy[rs2_d] || mBusy[rd_d];
    cap = mc_op_d && (mPending == MAXP);
    h   = lu || sbh || cap;
    if (redirect_e) return {fwdModel(rs1_e), fwdModel(rs2_e), 4'b0011};
    return {fwdModel(rs1_e), fwdModel(rs2_e), h, h, 1'b0, h};
  endfunction

  task automatic clearIn();
    rs1_d = '0; rs2_d = '0; rd_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0; mc_rd = '0; mc_op_d = 1'b0; load_e = 1'b0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mc_issue_e = 1'b0; mc_done = 1'b0; redirect_e = 1'b0;
  endtask

  task automatic applyHz(input hz_t h);
    clearIn();
    load_e = h.ld; reg_write_e = h.we; rd_e = h.rde; rs1_d = h.rs1d; rs2_d = h.rs2d;
    rd_d = h.rdd; mc_op_d = h.mcop; mc_issue_e = h.iss; mc_done = h.done;
    mc_rd = h.mcrd; redirect_e = h.redir;
  endtask

  // Advance one clock, updating the model state the same way the edge should
  task automatic tick();
    logic [31:0] nb;
    int          np;
    logic [7:0]  c;
    int unsigned ns, nf;
    nb = mBusy; np = mPending; c = expCtl(); ns = mStall; nf = mFlush;
    if (reset) begin
      nb = '0; np = 0; ns = 0; nf = 0;
    end else begin
      if (mc_done) nb[mc_rd] = 1'b0;
      if (mc_issue_e && rd_e != 5'd0) nb[rd_e] = 1'b1;
      if (mc_issue_e && !mc_done) np++;
      else if (mc_done && !mc_issue_e) np--;
      if (c[2]) ns++;
      if (c[1] || c[0]) nf++;
    end
    @(posedge clk); #1;
    mBusy = nb; mPending = np; mStall = ns; mFlush = nf;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    clearIn();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    expQ.push_back(8'h00);
    @(negedge clk);
    e = expQ.pop_front();
    total++;
    if (ctl !== e) $display("FAIL reset_ctl got %b want %b", ctl, e); else passed++;
    total++;
    if (sb_busy !== 32'h0) $display("FAIL reset_sb_busy got %h want 00000000", sb_busy); else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (stall_cycles !== '0 || flush_cycles !== '0)
      $display("FAIL reset_perf got %0d/%0d want 0/0", stall_cycles, flush_cycles);
    else passed++;
`endif
    tick();
  endtask

  task automatic test_forward();
    fwd_t tbl[$];
    logic [7:0] e;
    tbl.push_back(fw(5, 0, 5, 5, 1, 1, 'b1000_0000));
    tbl.push_back(fw(5, 0, 5, 5, 0, 1, 'b0100_0000));
    tbl.push_back(fw(0, 0, 5, 5, 0, 1, 'b0000_0000));
    tbl.push_back(fw(6, 7, 7, 6, 1, 1, 'b0110_0000));
    tbl.push_back(fw(8, 8, 8, 8, 0, 0, 'b0000_0000));
    tbl.push_back(fw(31, 31, 31, 0, 1, 1, 'b1010_0000));
    tbl.push_back(fw(0, 0, 0, 0, 1, 1, 'b0000_0000));
    foreach (tbl[i]) begin
      clearIn();
      rs1_e = tbl[i].rs1e; rs2_e = tbl[i].rs2e; rd_m = tbl[i].rdm; rd_w = tbl[i].rdw;
      reg_write_m = tbl[i].wm; reg_write_w = tbl[i].ww;
      expQ.push_back(tbl[i].ex);
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL forward[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      tick();
    end
  endtask

  task automatic test_load_use();
    hz_t s[$];
    logic [7:0] e;
    s.push_back(hz(1, 1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 'h00));
    s.push_back(hz(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00));
    s.push_back(hz(1, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(1, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 'h00));
    s.push_back(hz(0, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 'h00));
    s.push_back(hz(1, 1, 4, 0, 0, 4, 0, 0, 0, 0, 0, 'h00));
    foreach (s[i]) begin
      applyHz(s[i]);
      expQ.push_back(s[i].ex);
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL load_use[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      tick();
    end
  endtask

  task automatic test_scoreboard();
    hz_t s[$];
    logic [7:0] e;
    s.push_back(hz(0, 0, 9, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 9, 0, 0, 0, 0, 1, 9, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 11, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 0, 11, 0, 0, 0, 1, 11, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0, 'h00));
    foreach (s[i]) begin
      applyHz(s[i]);
      expQ.push_back(s[i].ex);
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL scoreboard[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      total++;
      if (sb_busy !== mBusy) $display("FAIL scoreboard[%0d] sb_busy got %h want %h", i, sb_busy, mBusy); else passed++;
      tick();
    end
  endtask

  task automatic test_same_cycle();
    hz_t s[$];
    logic [7:0] e;
    s.push_back(hz(0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 3, 0, 0, 0, 0, 1, 1, 3, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 10, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 1, 2, 6, 1, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 'h00));
    s.push_back(hz(0, 0, 0, 3, 10, 0, 1, 0, 0, 0, 0, 'h00));
    foreach (s[i]) begin
      applyHz(s[i]);
      expQ.push_back(s[i].ex);
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL same_cycle[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      total++;
      if (sb_busy !== mBusy) $display("FAIL same_cycle[%0d] sb_busy got %h want %h", i, sb_busy, mBusy); else passed++;
      tick();
    end
  endtask

  task automatic test_capacity();
    hz_t s[$];
    logic [7:0] e;
    s.push_back(hz(0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 1, 2, 6, 1, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 1, 2, 6, 1, 0, 1, 4, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 1, 2, 6, 1, 0, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 1, 2, 6, 1, 0, 0, 0, 0, 'h0D));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h00));
    s.push_back(hz(0, 0, 0, 1, 2, 6, 1, 0, 0, 0, 0, 'h00));
    foreach (s[i]) begin
      applyHz(s[i]);
      expQ.push_back(s[i].ex);
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL capacity[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      total++;
      if (sb_busy !== mBusy) $display("FAIL capacity[%0d] sb_busy got %h want %h", i, sb_busy, mBusy); else passed++;
      tick();
    end
  endtask

  task automatic test_redirect();
    hz_t s[$];
    logic [7:0] e;
    s.push_back(hz(1, 1, 7, 0, 7, 0, 0, 0, 0, 0, 1, 'h03));
    s.push_back(hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h03));
    s.push_back(hz(1, 1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 'h0D));
    foreach (s[i]) begin
      applyHz(s[i]);
      expQ.push_back(s[i].ex);
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL redirect[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      tick();
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (flush_cycles !== CNT_W'(mFlush) || stall_cycles !== CNT_W'(mStall))
        $display("FAIL redirect_perf[%0d] got stall %0d flush %0d want stall %0d flush %0d",
                 i, stall_cycles, flush_cycles, mStall, mFlush);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    applyHz(hz(0, 0, 12, 0, 0, 0, 0, 1, 0, 0, 0, 'h00));
    tick();
    clearIn();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyHz(hz(0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 'h00));
    expQ.push_back(8'h00);
    @(negedge clk);
    e = expQ.pop_front();
    total++;
    if (ctl !== e) $display("FAIL reset_mid_ctl got %b want %b", ctl, e); else passed++;
    total++;
    if (sb_busy !== 32'h0) $display("FAIL reset_mid_sb_busy got %h want 00000000", sb_busy); else passed++;
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (stall_cycles !== '0 || flush_cycles !== '0)
      $display("FAIL reset_mid_perf got %0d/%0d want 0/0", stall_cycles, flush_cycles);
    else passed++;
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int i = 0; i < 80; i++) begin
      clearIn();
      rs1_e = 5'($urandom_range(0, 15)); rs2_e = 5'($urandom_range(0, 15));
      rd_m = 5'($urandom_range(0, 15));  rd_w = 5'($urandom_range(0, 15));
      reg_write_m = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
      rs1_d = 5'($urandom_range(0, 15)); rs2_d = 5'($urandom_range(0, 15));
      rd_d = 5'($urandom_range(0, 15));  rd_e = 5'($urandom_range(0, 15));
      load_e = 1'($urandom_range(0, 1)); reg_write_e = 1'($urandom_range(0, 1));
      mc_op_d = 1'($urandom_range(0, 1));
      mc_issue_e = (mPending < MAXP) ? 1'($urandom_range(0, 1)) : 1'b0;
      mc_done = (mPending > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      mc_rd = 5'($urandom_range(0, 15));
      redirect_e = ($urandom_range(0, 7) == 0);
      expQ.push_back(expCtl());
      @(negedge clk);
      e = expQ.pop_front();
      total++;
      if (ctl !== e) $display("FAIL random[%0d] ctl got %b want %b", i, ctl, e); else passed++;
      total++;
      if (sb_busy !== mBusy) $display("FAIL random[%0d] sb_busy got %h want %h", i, sb_busy, mBusy); else passed++;
      tick();
    end
    for (int k = 0; k < 8 && mPending > 0; k++) begin
      clearIn();
      mc_done = 1'b1;
      tick();
    end
    clearIn();
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (stall_cycles !== CNT_W'(mStall) || flush_cycles !== CNT_W'(mFlush))
      $display("FAIL random_perf got stall %0d flush %0d want stall %0d flush %0d",
               stall_cycles, flush_cycles, mStall, mFlush);
    else passed++;
`endif
  endtask

  initial begin
    reset = 1'b1;
    clearIn();
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_same_cycle();
    test_capacity();
    test_redirect();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Pipeline hazard controller for the 5-stage RV32 core, replacing the purely combinational hazard logic. It adds a register scoreboard for variable-latency multi-cycle units (mul/div, slow loads) that write back out of band. It also adds a parametrised outstanding-operation limit and registered stall/flush statistics. It sits beside the D/E/M/W pipeline registers and drives their stall, flush and forward-select controls.

## Interface
Parameters:
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.
- MAX_PENDING, 4, maximum outstanding multi-cycle operations (1..NUM_REGS-1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rs1_d, rs2_d, rd_d  in  REG_AW  source and destination registers of the instruction in D.
- mc_op_d  in  1  the D instruction is a multi-cycle op.
- rs1_e, rs2_e, rd_e  in  REG_AW  register fields of the instruction in E.
- load_e  in  1  the E instruction is a single-cycle-latency load.
- reg_write_e, reg_write_m, reg_write_w  in  1  register-write enables per stage.
- rd_m, rd_w  in  REG_AW  destination registers in M and W.
- mc_issue_e  in  1  the multi-cycle op in E is accepted by its unit this cycle.
- mc_done  in  1  a multi-cycle unit writes the register file this cycle.
- mc_rd  in  REG_AW  destination of mc_done.
- redirect_e  in  1  taken branch or jump resolved in E.
- fwd_a_e, fwd_b_e  out  2  E operand select: 00 register file, 01 W result, 10 M result.
- stall_f, stall_d  out  1  hold the PC and the D register.
- flush_d, flush_e  out  1  bubble the D and E registers.
- sb_busy  out  NUM_REGS  scoreboard bitmap, for debug.

## Operation
- Forwarding: select 10 when rsX_e == rd_m && reg_write_m && rsX_e != 0. Otherwise select 01 when rsX_e == rd_w && reg_write_w && rsX_e != 0. Otherwise select 00. M has priority over W.
- load_use: load_e && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).
- sb_hit: sb_busy[rs1_d] || sb_busy[rs2_d] || sb_busy[rd_d] (the last covers WAW). Bit 0 is never set.
- cap_full: mc_op_d && pending == MAX_PENDING.
- hz_stall = load_use || sb_hit || cap_full.
- If redirect_e: stall_f = stall_d = 0, flush_d = flush_e = 1. Redirect overrides every stall.
- Otherwise: stall_f = stall_d = hz_stall, flush_e = hz_stall, flush_d = 0.
- Scoreboard update on each clk edge:
  - mc_issue_e with rd_e != 0 sets sb_busy[rd_e] and increments pending.
  - mc_done clears sb_busy[mc_rd] and decrements pending.
  - If both events hit the same register in one cycle, the set wins: the newer writer stays pending.
  - If both events occur in one cycle, pending is unchanged.
- mc_issue_e with rd_e == 0 still counts in pending. Its completion arrives with mc_rd == 0 and decrements pending.
- mc_done while pending == 0 is a protocol error: pending does not underflow, and a simulation assertion fires.
- mc_issue_e while pending == MAX_PENDING is a protocol error: pending saturates, and a simulation assertion fires.
- The W-stage forward does not cover mc_done writes. The register file writes first and reads second.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and the current scoreboard state. There are no added cycles.
- Scoreboard and pending counter update take effect the cycle after issue or done. A D instruction that depends on mc_rd can proceed in the cycle after mc_done.
- Reset: sb_busy = 0, pending = 0, performance counters = 0. With all inputs at 0, every output is 0.
- Reset asserted mid-operation discards all pending state. The multi-cycle units must be reset in the same cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined adds these outputs:
  - stall_cycles: counts cycles with stall_d = 1.
  - flush_cycles: counts cycles with flush_d || flush_e.
  - Both are CNT_W wide, saturate at all-ones, and are cleared by reset.
- Without the macro, the ports and registers are absent and behaviour is otherwise identical.

## Structure
- hazard_pkg holds:
  - the fwd_sel_e enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - the localparam function for the pending width, $clog2(MAX_PENDING+1).
- Sub-module hazard_scoreboard holds the sb_busy bitmap, the pending counter and the protocol assertions. The top level holds the forwarding, stall/flush priority and performance counters.

## Test plan
- Forward priority: rs1_e = 5, rd_m = 5, rd_w = 5, both write enables set -> fwd_a_e = 10. Then clear reg_write_m -> 01. Then set rs1_e = 0 -> 00.
- Load-use: load_e = 1, rd_e = 7, rs2_d = 7 -> stall_f = stall_d = flush_e = 1 for exactly one cycle. Repeat with rd_e = 0 -> no stall.
- Scoreboard: mc_issue_e with rd_e = 9. Next cycle rs1_d = 9 -> stall held. Pulse mc_done with mc_rd = 9 -> stall drops the following cycle, and sb_busy[9] = 0.
- Same-cycle set and clear: mc_issue_e with rd_e = 3 and mc_done with mc_rd = 3 together -> sb_busy[3] = 1, pending unchanged.
- Capacity: MAX_PENDING = 2, two issues to x4 and x5, then mc_op_d = 1 with unrelated registers -> stall. One mc_done -> stall released.
- Redirect over stall: load_use active and redirect_e = 1 -> stall_f = stall_d = 0, flush_d = flush_e = 1. With HAZARD_PERF_CNT_EN defined, flush_cycles increments by 1.
